stage_four: RTL and testbench

//  One stage of a two-phase (transition-signalling) bundled-data pipeline, 3-bit payload.

---
 rtl/stage_four.sv | 95 +++++++++
 tb/tb_stage_four.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_four.sv
// rtl/stage_four.sv - two-phase bundled-data pipeline stage with programmable forward delay
module stage_four #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int DELAY       = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             ack_out,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   input  logic             ack_in
);

   localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_WAIT_ACK
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          valid_sync;
   logic          ack_sync;

   // Handshake wires may arrive from another timing domain; data is bundled and
   // only sampled once the synchronized request says it is stable.
   generate
      if (SYNC_STAGES == 0) begin : g_raw
         assign valid_sync = valid_in;
         assign ack_sync   = ack_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] v_sync;
         logic [SYNC_STAGES-1:0] a_sync;

         always_ff @(posedge clk) begin
            if (rst) begin
               v_sync <= '0;
               a_sync <= '0;
            end else begin
               v_sync[0] <= valid_in;
               a_sync[0] <= ack_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  v_sync[i] <= v_sync[i-1];
                  a_sync[i] <= a_sync[i-1];
               end
            end
         end

         assign valid_sync = v_sync[SYNC_STAGES-1];
         assign ack_sync   = a_sync[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         count     <= '0;
         ack_out   <= 1'b0;
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Phase mismatch between request and our ack means a token is waiting.
               if (valid_sync != ack_out) begin
                  data_out <= data_in;
                  ack_out  <= ~ack_out;
                  count    <= CW'(DELAY - 1);
                  state    <= ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (count == '0) begin
                  valid_out <= ~valid_out;
                  state     <= ST_WAIT_ACK;
               end else begin
                  count <= count - CW'(1);
               end
            end
            ST_WAIT_ACK: begin
               if (ack_sync == valid_out) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_four.sv
// tb/tb_stage_four.sv - randomized and directed bench for stage_four against a timed token model
module tb_stage_four;

   localparam int WIDTH  = 3;
   localparam int SYNC   = 2;
   localparam int DLY    = 2;
   localparam int TOKENS = 40;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             valid_in = 1'b0;
   logic             ack_in = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             ack_out;
   logic             valid_out;
   logic [WIDTH-1:0] data_out;

   int checks = 0;
   int errors = 0;

   stage_four #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DELAY(DLY)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_in),
      .data_in  (data_in),
      .ack_out  (ack_out),
      .valid_out(valid_out),
      .data_out (data_out),
      .ack_in   (ack_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference: a token is accepted when the input phase seen SYNC edges late
   // differs from our ack phase; it is forwarded exactly DLY edges later and
   // released once the delayed downstream phase matches.
   bit         vhist[$];
   bit         ahist[$];
   bit         m_ack = 0, m_vout = 0, m_busy = 0, m_fired = 0;
   logic [2:0] m_data = '0;
   int         edge_n = 0;
   int         m_fire = 0;

   initial begin
      for (int i = 0; i < SYNC; i++) begin
         vhist.push_back(1'b0);
         ahist.push_back(1'b0);
      end
   end

   always @(posedge clk) begin : model
      bit vs_m, as_m;
      vs_m = vhist.pop_front();
      as_m = ahist.pop_front();
      vhist.push_back(rst ? 1'b0 : valid_in);
      ahist.push_back(rst ? 1'b0 : ack_in);
      if (rst) begin
         m_ack = 0; m_vout = 0; m_busy = 0; m_fired = 0; m_data = '0;
      end else if (!m_busy) begin
         if (vs_m != m_ack) begin
            m_ack   = ~m_ack;
            m_data  = data_in;
            m_busy  = 1;
            m_fired = 0;
            m_fire  = edge_n + DLY;
         end
      end else if (!m_fired) begin
         if (edge_n == m_fire) begin
            m_vout  = ~m_vout;
            m_fired = 1;
         end
      end else if (as_m == m_vout) begin
         m_busy = 0;
      end
      edge_n++;
   end

   always @(negedge clk) begin
      check("ack_out_model", ack_out, m_ack);
      check("valid_out_model", valid_out, m_vout);
      check("data_out_model", data_out, m_data);
   end

   logic [2:0] sentq[$];
   logic [2:0] nxt;
   logic [2:0] exp_d;
   logic       prev_vout;
   int         sent, fwd, up_wait, dn_wait;

   initial begin
      // Reset
      step(2);
      check("reset_ack_out", ack_out, 0);
      check("reset_valid_out", valid_out, 0);
      check("reset_data_out", data_out, 0);

      // First token after reset and its latency
      rst = 1'b0; valid_in = 1'b1; data_in = 3'd1;
      step(2);
      check("lat_ack_before", ack_out, 0);
      step(1);
      check("lat_ack_edge3", ack_out, 1);
      check("lat_data", data_out, 1);
      step(1);
      check("lat_vout_before", valid_out, 0);
      step(1);
      check("lat_vout_edge5", valid_out, 1);

      // Downstream withholds ack: new token must wait
      valid_in = 1'b0; data_in = 3'd5;
      step(6);
      check("hold_ack_out", ack_out, 1);
      check("hold_valid_out", valid_out, 1);
      check("hold_data_out", data_out, 1);
      ack_in = 1'b1;
      step(3);
      check("release_ack_before", ack_out, 1);
      step(1);
      check("release_ack_out", ack_out, 0);
      check("release_data_out", data_out, 5);
      step(2);
      check("release_valid_out", valid_out, 0);

      // Ack and new request seen on the same edge
      ack_in = 1'b0; valid_in = 1'b1; data_in = 3'd6;
      step(3);
      check("same_edge_ack_before", ack_out, 0);
      step(1);
      check("same_edge_ack_out", ack_out, 1);
      check("same_edge_data", data_out, 6);

      // Reset while the token is being delayed
      rst = 1'b1; valid_in = 1'b0; ack_in = 1'b0;
      step(1);
      check("mid_reset_ack", ack_out, 0);
      check("mid_reset_vout", valid_out, 0);
      check("mid_reset_data", data_out, 0);
      step(2);
      rst = 1'b0;
      step(6);
      check("post_reset_vout", valid_out, 0);
      check("post_reset_ack", ack_out, 0);

      // Randomized echo environment with an incrementing payload
      sent = 0; fwd = 0; nxt = 3'd1; prev_vout = valid_out;
      up_wait = $urandom_range(0, 4);
      dn_wait = $urandom_range(0, 4);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (sent == TOKENS && fwd == TOKENS && ack_in == valid_out) break;
         @(negedge clk);
         if (valid_out != prev_vout) begin
            prev_vout = valid_out;
            if (sentq.size() > 0) begin
               exp_d = sentq.pop_front();
               check("fwd_data", data_out, exp_d);
            end else begin
               check("fwd_unexpected_token", 1, 0);
            end
            check("fwd_sequence", data_out, (fwd + 1) % 8);
            fwd++;
         end
         if (ack_in != valid_out) begin
            if (dn_wait == 0) begin
               ack_in  = valid_out;
               dn_wait = $urandom_range(0, 4);
            end else begin
               dn_wait--;
            end
         end
         if (valid_in == ack_out && sent < TOKENS) begin
            if (up_wait == 0) begin
               data_in  = nxt;
               valid_in = ~valid_in;
               sentq.push_back(nxt);
               nxt++;
               sent++;
               up_wait = $urandom_range(0, 4);
            end else begin
               up_wait--;
            end
         end
      end
      check("tokens_forwarded", fwd, TOKENS);
      check("tokens_left", sentq.size(), 0);
      step(8);
      check("idle_vout_stable", valid_out, prev_vout);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
